// File: rtl/approx_mac_pe.sv
// approx_mac_pe
// Pipelined approximate multiply-accumulate processing element.
// Each accepted beat produces an N x N unsigned product, either exact or with
// the K lowest product columns replaced by a per-column OR. Products are summed
// into an accumulator until a beat flagged 'last' closes the group. The group
// result is then presented on a registered output with valid/ready handshake.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operand beat valid
//   in_ready   : beat can be accepted this cycle
//   in_a/in_b  : unsigned N-bit operands
//   in_approx  : 1 = approximate product for this beat
//   in_last    : final beat of the accumulation group
//   out_valid  : group result available
//   out_ready  : consumer accepts the result
//   out_acc    : group sum modulo 2^ACC_W
//   out_ovf    : a carry out of ACC_W occurred within the group
//   out_beats  : beats in the group, saturating at 255
module approx_mac_pe #(
    parameter int N     = 4,
    parameter int K     = 4,
    parameter int ACC_W = 2 * N + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_approx,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [7:0]       out_beats
);

    localparam int PW = 2 * N;

    // Product of a and b. In approximate mode every partial product landing in
    // a column below K is ORed into that column's bit; all other partial
    // products are added. Terms from columns >= K are multiples of 2^K, so
    // their sum never touches the low region and the two halves can be ORed.
    function automatic logic [PW-1:0] mult_prod(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic         approx
    );
        logic [PW-1:0] high_sum;
        logic [PW-1:0] low_bits;
        logic [PW-1:0] term;
        high_sum = '0;
        low_bits = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                term        = '0;
                term[i + j] = a[i] & b[j];
                if ((approx == 1'b1) && ((i + j) < K)) begin
                    low_bits = low_bits | term;
                end else begin
                    high_sum = high_sum + term;
                end
            end
        end
        return high_sum | low_bits;
    endfunction

    // Stage-1 registers
    logic              s1_valid_r;
    logic              s1_last_r;
    logic [PW-1:0]     s1_prod_r;

    // Accumulator state for the open group
    logic [ACC_W-1:0]  acc_r;
    logic              ovf_r;
    logic [7:0]        cnt_r;

    // Output registers
    logic              out_valid_r;
    logic [ACC_W-1:0]  out_acc_r;
    logic              out_ovf_r;
    logic [7:0]        out_beats_r;

    // Combinational helpers
    logic              stall_s;
    logic              accept_s;
    logic              fire_s;
    logic [PW-1:0]     prod_s;
    logic [ACC_W:0]    sum_s;
    logic              grp_ovf_s;
    logic [7:0]        cnt_inc_s;

    // Handshake control, product and accumulate datapath.
    // A closing beat can only retire when the output slot is free or being
    // drained this cycle; every other beat always retires.
    always_comb begin
        stall_s   = 1'b0;
        accept_s  = 1'b0;
        fire_s    = 1'b0;
        prod_s    = '0;
        sum_s     = '0;
        grp_ovf_s = 1'b0;
        cnt_inc_s = 8'd0;

        stall_s   = s1_valid_r & s1_last_r & out_valid_r & ~out_ready;
        accept_s  = in_valid & ~stall_s;
        fire_s    = s1_valid_r & ~stall_s;
        prod_s    = mult_prod(in_a, in_b, in_approx);
        sum_s     = {1'b0, acc_r} + (ACC_W + 1)'(s1_prod_r);
        grp_ovf_s = ovf_r | sum_s[ACC_W];
        if (cnt_r == 8'd255) begin
            cnt_inc_s = 8'd255;
        end else begin
            cnt_inc_s = cnt_r + 8'd1;
        end
    end

    // Stage 1: capture the product of an accepted beat; holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_prod_r  <= '0;
        end else if (!stall_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_last_r <= in_last;
                s1_prod_r <= prod_s;
            end else begin
                s1_last_r <= s1_last_r;
                s1_prod_r <= s1_prod_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_last_r  <= s1_last_r;
            s1_prod_r  <= s1_prod_r;
        end
    end

    // Stage 2: accumulate the open group; clears once the group closes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= '0;
            ovf_r <= 1'b0;
            cnt_r <= 8'd0;
        end else if (fire_s) begin
            if (s1_last_r) begin
                acc_r <= '0;
                ovf_r <= 1'b0;
                cnt_r <= 8'd0;
            end else begin
                acc_r <= sum_s[ACC_W-1:0];
                ovf_r <= grp_ovf_s;
                cnt_r <= cnt_inc_s;
            end
        end else begin
            acc_r <= acc_r;
            ovf_r <= ovf_r;
            cnt_r <= cnt_r;
        end
    end

    // Output slot: a reload wins over a drain in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_acc_r   <= '0;
            out_ovf_r   <= 1'b0;
            out_beats_r <= 8'd0;
        end else if (fire_s && s1_last_r) begin
            out_valid_r <= 1'b1;
            out_acc_r   <= sum_s[ACC_W-1:0];
            out_ovf_r   <= grp_ovf_s;
            out_beats_r <= cnt_inc_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_acc_r   <= out_acc_r;
            out_ovf_r   <= out_ovf_r;
            out_beats_r <= out_beats_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_acc_r   <= out_acc_r;
            out_ovf_r   <= out_ovf_r;
            out_beats_r <= out_beats_r;
        end
    end

    assign in_ready  = ~stall_s;
    assign out_valid = out_valid_r;
    assign out_acc   = out_acc_r;
    assign out_ovf   = out_ovf_r;
    assign out_beats = out_beats_r;

endmodule

// File: tb/tb_approx_mac_pe.sv
// Testbench for approx_mac_pe. Four instances share one stimulus stream:
//   u0: N=4 K=4 ACC_W=12   u1: N=4 K=4 ACC_W=8
//   u2: N=4 K=0 ACC_W=12   u3: N=4 K=7 ACC_W=12
// Handshake timing does not depend on data, so all instances move in lockstep.
// Expected group results are pushed per instance when the closing beat is
// accepted and popped when the instance hands a result over.
module tb_approx_mac_pe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_approx;
    logic       in_last;
    logic       out_ready;

    logic        rdy_o   [4];
    logic        ov_o    [4];
    logic [11:0] acc_o   [4];
    logic        ovf_o   [4];
    logic [7:0]  beats_o [4];
    logic [7:0]  acc1_w;

    int checks   = 0;
    int failures = 0;

    int k_arr[4] = '{4, 4, 0, 7};
    int w_arr[4] = '{12, 8, 12, 12};
    int acc_m[4];
    int ovf_m[4];
    int cnt_m[4];
    logic [31:0] exp_q[4][$];

    always #5 clk = ~clk;

    approx_mac_pe #(.N(4), .K(4), .ACC_W(12)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[0]),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .in_last(in_last),
        .out_valid(ov_o[0]), .out_ready(out_ready), .out_acc(acc_o[0]),
        .out_ovf(ovf_o[0]), .out_beats(beats_o[0]));

    approx_mac_pe #(.N(4), .K(4), .ACC_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[1]),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .in_last(in_last),
        .out_valid(ov_o[1]), .out_ready(out_ready), .out_acc(acc1_w),
        .out_ovf(ovf_o[1]), .out_beats(beats_o[1]));
    assign acc_o[1] = {4'b0000, acc1_w};

    approx_mac_pe #(.N(4), .K(0), .ACC_W(12)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[2]),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .in_last(in_last),
        .out_valid(ov_o[2]), .out_ready(out_ready), .out_acc(acc_o[2]),
        .out_ovf(ovf_o[2]), .out_beats(beats_o[2]));

    approx_mac_pe #(.N(4), .K(7), .ACC_W(12)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[3]),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .in_last(in_last),
        .out_valid(ov_o[3]), .out_ready(out_ready), .out_acc(acc_o[3]),
        .out_ovf(ovf_o[3]), .out_beats(beats_o[3]));

    // Reference product: count the partial products in each column; columns
    // at or above k contribute count * 2^c, columns below k contribute one bit
    // if any partial product there is set.
    function automatic int ref_prod(input int a, input int b, input bit apx, input int k);
        int res;
        int cnt;
        int j;
        if (!apx) return a * b;
        res = 0;
        for (int c = 0; c <= 6; c++) begin
            cnt = 0;
            for (int i = 0; i < 4; i++) begin
                j = c - i;
                if (j >= 0 && j < 4 && ((a >> i) & 1) == 1 && ((b >> j) & 1) == 1) cnt++;
            end
            if (c >= k) res += cnt << c;
            else if (cnt != 0) res += 1 << c;
        end
        return res;
    endfunction

    function automatic void model_accept(input int a, input int b, input bit apx, input bit lst);
        int s;
        for (int k = 0; k < 4; k++) begin
            s = acc_m[k] + ref_prod(a, b, apx, k_arr[k]);
            if (s >= (1 << w_arr[k])) begin
                s = s - (1 << w_arr[k]);
                ovf_m[k] = 1;
            end
            acc_m[k] = s;
            cnt_m[k] = (cnt_m[k] == 255) ? 255 : cnt_m[k] + 1;
            if (lst) begin
                exp_q[k].push_back(32'(acc_m[k] | (ovf_m[k] << 12) | (cnt_m[k] << 13)));
                acc_m[k] = 0;
                ovf_m[k] = 0;
                cnt_m[k] = 0;
            end
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 4; k++) begin
            acc_m[k] = 0;
            ovf_m[k] = 0;
            cnt_m[k] = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
        end
    endtask

    // Drive one beat at a falling edge and hold it until accepted (bounded).
    task automatic send_beat(input int a, input int b, input bit apx, input bit lst, input bit ordy);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a[3:0];
        in_b      = b[3:0];
        in_approx = apx;
        in_last   = lst;
        out_ready = ordy;
        #1;
        n = 0;
        while (rdy_o[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            n++;
        end
        checks++;
        assert (n < 50) else begin
            failures++;
            $error("FAIL accept_timeout got=%0d exp=<50", n);
        end
        if (n < 50) begin
            @(posedge clk);
            model_accept(a, b, apx, lst);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for u0 to present a result; n = falling edges waited.
    task automatic wait_out(output int n);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n = 1;
        while (ov_o[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        assert (n < 20) else begin
            failures++;
            $error("FAIL out_timeout got=%0d exp=<20", n);
        end
    endtask

    // Scoreboard: every handshaken result must match the oldest expectation.
    always @(negedge clk) begin
        logic [31:0] got;
        logic [31:0] expv;
        #2;
        if (rst_n === 1'b1 && out_ready === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                if (ov_o[k] === 1'b1) begin
                    checks++;
                    assert (exp_q[k].size() > 0) else begin
                        failures++;
                        $error("FAIL sb_unexpected inst=%0d got=%0d exp=none", k, acc_o[k]);
                    end
                    if (exp_q[k].size() > 0) begin
                        expv = exp_q[k].pop_front();
                        got  = {11'b0, beats_o[k], ovf_o[k], acc_o[k]};
                        checks++;
                        assert (got === expv) else begin
                            failures++;
                            $error("FAIL sb_result inst=%0d got acc=%0d ovf=%0d beats=%0d exp acc=%0d ovf=%0d beats=%0d",
                                   k, got[11:0], got[12], got[20:13], expv[11:0], expv[12], expv[20:13]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int a;
        int b;
        bit apx;
        bit lst;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 4'd0;
        in_b      = 4'd0;
        in_approx = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(ov_o[0]), 32'd0);
        chk("rst_acc", 32'(acc_o[0]), 32'd0);
        chk("rst_ovf", 32'(ovf_o[0]), 32'd0);
        chk("rst_beats", 32'(beats_o[0]), 32'd0);
        chk("rst_ready", 32'(rdy_o[0]), 32'd1);
        rst_n = 1'b1;

        // Single-beat groups
        send_beat(15, 15, 1'b1, 1'b1, 1'b1);
        wait_out(n);
        chk("latency", 32'(n), 32'd2);
        chk("s_15x15_apx", 32'(acc_o[0]), 32'd191);
        chk("s_beats", 32'(beats_o[0]), 32'd1);
        send_beat(15, 15, 1'b0, 1'b1, 1'b1);
        wait_out(n);
        chk("s_15x15_exact", 32'(acc_o[0]), 32'd225);
        send_beat(3, 3, 1'b1, 1'b1, 1'b1);
        wait_out(n);
        chk("s_3x3_apx", 32'(acc_o[0]), 32'd7);
        send_beat(3, 3, 1'b0, 1'b1, 1'b1);
        wait_out(n);
        chk("s_3x3_exact", 32'(acc_o[0]), 32'd9);

        // Three-beat groups
        send_beat(15, 15, 1'b1, 1'b0, 1'b1);
        send_beat(3, 3, 1'b1, 1'b0, 1'b1);
        send_beat(1, 1, 1'b1, 1'b1, 1'b1);
        wait_out(n);
        chk("g_apx", 32'(acc_o[0]), 32'd199);
        chk("g_apx_beats", 32'(beats_o[0]), 32'd3);
        send_beat(15, 15, 1'b0, 1'b0, 1'b1);
        send_beat(3, 3, 1'b0, 1'b0, 1'b1);
        send_beat(1, 1, 1'b0, 1'b1, 1'b1);
        wait_out(n);
        chk("g_exact", 32'(acc_o[0]), 32'd235);
        send_beat(15, 15, 1'b1, 1'b0, 1'b1);
        send_beat(3, 3, 1'b0, 1'b0, 1'b1);
        send_beat(1, 1, 1'b1, 1'b1, 1'b1);
        wait_out(n);
        chk("g_mixed", 32'(acc_o[0]), 32'd201);

        // Overflow on the 8-bit accumulator instance
        send_beat(15, 15, 1'b0, 1'b0, 1'b1);
        send_beat(15, 15, 1'b0, 1'b1, 1'b1);
        wait_out(n);
        chk("w8_acc", 32'(acc_o[1]), 32'd194);
        chk("w8_ovf", 32'(ovf_o[1]), 32'd1);
        chk("w8_beats", 32'(beats_o[1]), 32'd2);
        chk("w12_ovf", 32'(ovf_o[0]), 32'd0);
        send_beat(1, 1, 1'b0, 1'b1, 1'b1);
        wait_out(n);
        chk("w8_next_acc", 32'(acc_o[1]), 32'd1);
        chk("w8_next_ovf", 32'(ovf_o[1]), 32'd0);

        // Backpressure: second closing beat waits in S1
        idle(1);
        out_ready = 1'b0;
        send_beat(2, 3, 1'b0, 1'b1, 1'b0);
        send_beat(4, 5, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_ready_low", 32'(rdy_o[0]), 32'd0);
        chk("bp_valid", 32'(ov_o[0]), 32'd1);
        chk("bp_first", 32'(acc_o[0]), 32'd6);
        repeat (3) @(negedge clk);
        #1;
        chk("bp_hold", 32'(acc_o[0]), 32'd6);
        chk("bp_ready_still_low", 32'(rdy_o[0]), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_back", 32'(rdy_o[0]), 32'd1);
        @(negedge clk);
        #1;
        chk("bp_reload_valid", 32'(ov_o[0]), 32'd1);
        chk("bp_second", 32'(acc_o[0]), 32'd20);
        @(negedge clk);
        #1;
        chk("bp_drained", 32'(ov_o[0]), 32'd0);

        // Reset in the middle of a group
        send_beat(7, 7, 1'b0, 1'b0, 1'b1);
        send_beat(7, 7, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        model_clear();
        @(negedge clk);
        #1;
        chk("mr_valid", 32'(ov_o[0]), 32'd0);
        chk("mr_acc", 32'(acc_o[0]), 32'd0);
        chk("mr_ovf", 32'(ovf_o[0]), 32'd0);
        chk("mr_beats", 32'(beats_o[0]), 32'd0);
        rst_n = 1'b1;
        send_beat(1, 2, 1'b0, 1'b1, 1'b1);
        wait_out(n);
        chk("mr_acc_after", 32'(acc_o[0]), 32'd2);
        chk("mr_beats_after", 32'(beats_o[0]), 32'd1);

        // Beat counter saturation
        for (int i = 0; i < 300; i++) begin
            send_beat(1, 1, 1'b0, (i == 299), 1'b1);
        end
        wait_out(n);
        chk("sat_beats", 32'(beats_o[0]), 32'd255);
        chk("sat_acc", 32'(acc_o[0]), 32'd300);
        chk("sat_w8_acc", 32'(acc_o[1]), 32'd44);
        chk("sat_w8_ovf", 32'(ovf_o[1]), 32'd1);

        // Random sweep: random groups, modes, gaps and out_ready
        for (int i = 0; i < 1000; i++) begin
            a   = int'($urandom_range(0, 15));
            b   = int'($urandom_range(0, 15));
            apx = ($urandom_range(0, 1) == 1);
            lst = (i == 999) || ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) idle(1);
            send_beat(a, b, apx, lst, ($urandom_range(0, 3) != 0));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(10);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_q%0d", k), 32'(exp_q[k].size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/approx_mac_pe.md
# approx_mac_pe

Parametrised, pipelined approximate multiply-accumulate processing element for the Strassen systolic array. It generalises the fixed 4x4 OR-compressor multiplier to N x N operands with a configurable number of approximate low-order columns and a per-beat exact/approximate mode. It accumulates a group of products delimited by a `last` flag under valid/ready flow control on both sides.

## Interface
- `N`, 4: operand width in bits; even, 4..16.
- `K`, 4: number of low product columns (0..2N-1) computed approximately when approx mode is active; K=0 is exact.
- `ACC_W`, 2*N+4: accumulator/result width; must be >= 2*N.
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block can accept a beat this cycle.
- `in_a` input N: unsigned multiplicand.
- `in_b` input N: unsigned multiplier.
- `in_approx` input 1: 1 = approximate product for this beat, 0 = exact.
- `in_last` input 1: final beat of the current accumulation group.
- `out_valid` output 1: group result available.
- `out_ready` input 1: consumer accepts result.
- `out_acc` output ACC_W: group sum, modulo 2^ACC_W.
- `out_ovf` output 1: sticky flag; a carry out of ACC_W occurred within the group.
- `out_beats` output 8: number of beats in the group, saturating at 255.

## Operation
- Partial products: pp[i][j] = in_a[i] & in_b[j]; column c = i+j.
- Exact product: sum of pp[i][j] << c over all i,j.
- Approximate product (in_approx=1): columns c >= K summed exactly, with carries propagating only among themselves. Each column c < K yields one bit, the OR of all pp in that column, placed at bit c. No carry leaves the low region. The result is 2N bits and never exceeds the exact product.
- Stage 1 (S1): on an accepted beat (in_valid & in_ready), register the product, `last` and valid. If no beat is accepted and S1 advances, S1 valid clears.
- Stage 2 (S2): when S1 is valid and not stalled:
  - sum = acc + zero-extended product; the carry out of ACC_W sets the group overflow.
  - Beat count increments, saturating at 255.
  - If S1 `last`: load `out_acc`/`out_ovf`/`out_beats` from sum, the final overflow and the final count, and set `out_valid`. acc, ovf and count then clear to 0.
  - Otherwise: acc <= sum.
- Output register: `out_valid` clears on out_valid & out_ready, unless it is reloaded in the same cycle. A reload wins and keeps `out_valid` at 1 with the new data.
- Stall = S1 valid & S1 last & out_valid & !out_ready. While stalled, S1 and the accumulator hold.
- `in_ready` = !stall, a combinational function of registered state and `out_ready`.
- Beats without `last` never stall. An unbounded group streams at one beat per cycle.

## Timing
- Reset (rst_n=0 at an edge): S1 valid, acc, group ovf, count, `out_valid`, `out_acc`, `out_ovf` and `out_beats` all go to 0. Any partial group is discarded.
- Latency: a beat accepted at edge E is in S1 after E and accumulated at edge E+1. If it is `last`, `out_valid` is high after edge E+1.
- Throughput: 1 beat/cycle, including back-to-back groups when `out_ready` is held at 1.
- Simultaneous output handshake and new `last`: the output is replaced with no bubble and no stall.
- `in_approx` is captured per beat, so a group may mix modes.
- Single-beat group: `out_beats`=1.

## Test plan
- N=4, K=4: single beats with `last`, out_ready=1.
  - (15,15,approx) -> out_acc=191.
  - (15,15,exact) -> 225.
  - (3,3,approx) -> 7.
  - (3,3,exact) -> 9.
  - `out_valid` rises 2 edges after in_valid, with `out_beats`=1.
- Group of (15,15),(3,3),(1,1), `last` on the third beat, all approx -> 199, beats=3. Same group all exact -> 235. Mixed (approx,exact,approx) -> 201.
- ACC_W=8: (15,15),(15,15) exact, with `last` -> out_acc=194, out_ovf=1. The next group (1,1) with `last` -> 1, ovf=0.
- out_ready=0: send two single-beat `last` groups (2,3) then (4,5).
  - First result is 6.
  - `in_ready` drops while (4,5) waits in S1.
  - Raise out_ready -> 20 follows on the next cycle, and no beat is lost or duplicated.
- Reset mid-group: accept (7,7),(7,7) with no `last`, assert rst_n=0 for 1 cycle, then send (1,2) with `last` -> out_acc=2, beats=1; all outputs read 0 during reset.
- K=0 random sweep of 1000 beats in random groups with random out_ready -> every result equals the exact reference sum. K=2N-1 sweep -> matches the OR-column model.
